// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the ALU issue slice.
//   ALU_XLEN   - datapath width carried in alu_cmd_t
//   alu_op_t   - 4-bit ALU opcode encoding
//   RV_*       - RV32 major opcodes handled by the decoder
//   F3_*/F7_*  - funct3 / funct7 field values
//   alu_cmd_t  - decoded ALU command {opcode, op1, op2, rd, illegal}
package alu_pkg;

    localparam int ALU_XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_AND  = 4'b0100,
        ALU_OR   = 4'b0101,
        ALU_XOR  = 4'b0110,
        ALU_SLL  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001
    } alu_op_t;

    localparam logic [6:0] RV_OP     = 7'b0110011;
    localparam logic [6:0] RV_OP_IMM = 7'b0010011;
    localparam logic [6:0] RV_LUI    = 7'b0110111;
    localparam logic [6:0] RV_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        alu_op_t               opcode;
        logic [ALU_XLEN-1:0]   op1;
        logic [ALU_XLEN-1:0]   op2;
        logic [4:0]            rd;
        logic                  illegal;
    } alu_cmd_t;

endpackage

// File: rtl/alu_decode.sv
// alu_decode: combinational RV32I OP / OP-IMM / LUI / AUIPC decoder.
//   instr - instruction word
//   pc    - instruction PC (AUIPC operand)
//   rs1   - rs1 register value
//   rs2   - rs2 register value
//   cmd   - decoded ALU command; illegal forces ADD with zero operands
module alu_decode
    import alu_pkg::*;
(
    input  logic [31:0]         instr,
    input  logic [ALU_XLEN-1:0] pc,
    input  logic [ALU_XLEN-1:0] rs1,
    input  logic [ALU_XLEN-1:0] rs2,
    output alu_cmd_t            cmd
);

    logic [6:0] major;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       bad;
    logic [ALU_XLEN-1:0] imm_i;
    logic [ALU_XLEN-1:0] imm_u;
    logic [ALU_XLEN-1:0] shamt;
    logic       unused_rs1_idx;

    assign major = instr[6:0];
    assign f3    = instr[14:12];
    assign f7    = instr[31:25];
    assign imm_i = {{(ALU_XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_u = {instr[31:12], 12'b0};
    assign shamt = {{(ALU_XLEN-5){1'b0}}, instr[24:20]};

    // Register indices arrive already resolved as rs1/rs2 values.
    assign unused_rs1_idx = ^instr[19:15];

    always_comb begin
        bad        = 1'b0;
        cmd        = '0;
        cmd.opcode = ALU_ADD;
        cmd.rd     = instr[11:7];

        case (major)
            RV_OP: begin
                cmd.op1 = rs1;
                cmd.op2 = rs2;
                case (f3)
                    F3_ADD_SUB: begin
                        if (f7 == F7_BASE)     cmd.opcode = ALU_ADD;
                        else if (f7 == F7_ALT) cmd.opcode = ALU_SUB;
                        else                   bad = 1'b1;
                    end
                    F3_SRL_SRA: begin
                        if (f7 == F7_BASE)     cmd.opcode = ALU_SRL;
                        else if (f7 == F7_ALT) cmd.opcode = ALU_SRA;
                        else                   bad = 1'b1;
                    end
                    F3_SLL:  cmd.opcode = ALU_SLL;
                    F3_SLT:  cmd.opcode = ALU_SLT;
                    F3_SLTU: cmd.opcode = ALU_SLTU;
                    F3_XOR:  cmd.opcode = ALU_XOR;
                    F3_OR:   cmd.opcode = ALU_OR;
                    F3_AND:  cmd.opcode = ALU_AND;
                    default: bad = 1'b1;
                endcase
                // Only ADD/SUB and SRL/SRA accept the alternate funct7.
                if ((f3 != F3_ADD_SUB) && (f3 != F3_SRL_SRA) && (f7 != F7_BASE))
                    bad = 1'b1;
            end
            RV_OP_IMM: begin
                cmd.op1 = rs1;
                cmd.op2 = imm_i;
                case (f3)
                    F3_ADD_SUB: cmd.opcode = ALU_ADD;
                    F3_SLT:     cmd.opcode = ALU_SLT;
                    F3_SLTU:    cmd.opcode = ALU_SLTU;
                    F3_XOR:     cmd.opcode = ALU_XOR;
                    F3_OR:      cmd.opcode = ALU_OR;
                    F3_AND:     cmd.opcode = ALU_AND;
                    F3_SLL: begin
                        cmd.opcode = ALU_SLL;
                        cmd.op2    = shamt;
                        if (f7 != F7_BASE) bad = 1'b1;
                    end
                    F3_SRL_SRA: begin
                        cmd.op2 = shamt;
                        if (f7 == F7_BASE)     cmd.opcode = ALU_SRL;
                        else if (f7 == F7_ALT) cmd.opcode = ALU_SRA;
                        else                   bad = 1'b1;
                    end
                    default: bad = 1'b1;
                endcase
            end
            RV_LUI: begin
                cmd.op1 = '0;
                cmd.op2 = imm_u;
            end
            RV_AUIPC: begin
                cmd.op1 = pc;
                cmd.op2 = imm_u;
            end
            default: bad = 1'b1;
        endcase

        if (bad) begin
            cmd.opcode = ALU_ADD;
            cmd.op1    = '0;
            cmd.op2    = '0;
        end
        cmd.illegal = bad;
    end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: execute-entry stage; decodes a slot packet and issues the ALU
// command through a 2-entry skid buffer (output register + skid entry).
//   CLK, RST_N              - clock, async active-low reset
//   in_valid / in_ready     - input handshake (in_ready is registered)
//   in_instr/pc/rs1/rs2     - decoded-slot packet
//   out_valid / out_ready   - ALU command handshake
//   out_opcode/op1/op2/rd   - ALU command fields
//   out_illegal             - instruction outside the supported subset
//
// state     | meaning
// BUF_EMPTY | no command held, output register invalid
// BUF_ONE   | output register holds a command, skid entry empty
// BUF_FULL  | output register and skid entry both hold commands
module alu_issue
    import alu_pkg::*;
#(
    parameter int XLEN = ALU_XLEN
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_opcode,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic [4:0]      out_rd,
    output logic            out_illegal
);

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

    buf_state_t state;
    alu_cmd_t   dec_cmd;
    alu_cmd_t   out_cmd;
    alu_cmd_t   skid_cmd;
    logic       in_acc;
    logic       out_acc;

    alu_decode u_decode (
        .instr (in_instr),
        .pc    (in_pc),
        .rs1   (in_rs1),
        .rs2   (in_rs2),
        .cmd   (dec_cmd)
    );

    assign in_acc  = in_valid & in_ready;
    assign out_acc = out_valid & out_ready;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= BUF_EMPTY;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_cmd   <= '0;
            skid_cmd  <= '0;
        end else begin
            case (state)
                BUF_EMPTY: begin
                    // Also the path that raises in_ready after reset release.
                    in_ready <= 1'b1;
                    if (in_acc) begin
                        out_cmd   <= dec_cmd;
                        out_valid <= 1'b1;
                        state     <= BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (in_acc && out_acc) begin
                        out_cmd <= dec_cmd;
                    end else if (in_acc) begin
                        // Output stalled: park the new command in the skid entry.
                        skid_cmd <= dec_cmd;
                        in_ready <= 1'b0;
                        state    <= BUF_FULL;
                    end else if (out_acc) begin
                        out_valid <= 1'b0;
                        state     <= BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    if (out_acc) begin
                        out_cmd  <= skid_cmd;
                        in_ready <= 1'b1;
                        state    <= BUF_ONE;
                    end
                end
                default: begin
                    state     <= BUF_EMPTY;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_opcode  = out_cmd.opcode;
    assign out_op1     = out_cmd.op1;
    assign out_op2     = out_cmd.op2;
    assign out_rd      = out_cmd.rd;
    assign out_illegal = out_cmd.illegal;

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;

    logic        CLK;
    logic        RST_N;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_opcode;
    logic [31:0] out_op1;
    logic [31:0] out_op2;
    logic [4:0]  out_rd;
    logic        out_illegal;

    int errors = 0;
    int checks = 0;

    alu_issue #(.XLEN(32)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_opcode  (out_opcode),
        .out_op1     (out_op1),
        .out_op2     (out_op2),
        .out_rd      (out_rd),
        .out_illegal (out_illegal)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Present one packet for one edge; returns 1 µs-free, cycle-bounded.
    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 10) begin
            @(posedge CLK); #1;
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL drive_in_ready: got %b want 1", in_ready);
        end
        in_instr = instr; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2;
        in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_pc = '0; in_rs1 = '0; in_rs2 = '0;
        #2 RST_N = 1'b0;
        #10;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: got out_valid=%b in_ready=%b want 0 0", out_valid, in_ready);
        end
        checks++;
        if ({out_opcode, out_op1, out_op2, out_rd, out_illegal} !== '0) begin
            errors++;
            $display("FAIL reset_data: got op=%h op1=%h op2=%h rd=%0d ill=%b want all 0",
                     out_opcode, out_op1, out_op2, out_rd, out_illegal);
        end
        #8 RST_N = 1'b1;   // released mid-cycle
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_before_edge: got %b want 0", in_ready);
        end
        @(posedge CLK); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_after_edge: got %b want 1", in_ready);
        end
    endtask

    task automatic test_op();
        drive(32'h002081B3, 32'h0, 32'd5, 32'd7);
        checks++;
        if (out_valid !== 1'b1 || out_opcode !== 4'b0000 || out_op1 !== 32'd5 ||
            out_op2 !== 32'd7 || out_rd !== 5'd3 || out_illegal !== 1'b0) begin
            errors++;
            $display("FAIL op_add: got v=%b op=%b op1=%h op2=%h rd=%0d ill=%b want 1 0000 5 7 3 0",
                     out_valid, out_opcode, out_op1, out_op2, out_rd, out_illegal);
        end
        drive(32'h402081B3, 32'h0, 32'd5, 32'd7);
        checks++;
        if (out_valid !== 1'b1 || out_opcode !== 4'b0001 || out_op1 !== 32'd5 || out_op2 !== 32'd7) begin
            errors++;
            $display("FAIL op_sub: got v=%b op=%b op1=%h op2=%h want 1 0001 5 7",
                     out_valid, out_opcode, out_op1, out_op2);
        end
        drive(32'h0020B233, 32'h0, 32'hA, 32'hB);
        checks++;
        if (out_opcode !== 4'b0011 || out_rd !== 5'd4 || out_illegal !== 1'b0) begin
            errors++;
            $display("FAIL op_sltu: got op=%b rd=%0d ill=%b want 0011 4 0", out_opcode, out_rd, out_illegal);
        end
        drive(32'h4020D233, 32'h0, 32'hF0000000, 32'd4);
        checks++;
        if (out_opcode !== 4'b1001 || out_op1 !== 32'hF0000000 || out_op2 !== 32'd4) begin
            errors++;
            $display("FAIL op_sra: got op=%b op1=%h op2=%h want 1001 f0000000 4", out_opcode, out_op1, out_op2);
        end
        @(posedge CLK); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL op_drain: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_imm();
        drive(32'hFFF00093, 32'h0, 32'h1234, 32'h5555);
        checks++;
        if (out_opcode !== 4'b0000 || out_op1 !== 32'h1234 || out_op2 !== 32'hFFFFFFFF || out_rd !== 5'd1) begin
            errors++;
            $display("FAIL imm_addi: got op=%b op1=%h op2=%h rd=%0d want 0000 1234 ffffffff 1",
                     out_opcode, out_op1, out_op2, out_rd);
        end
        drive(32'h40335293, 32'h0, 32'h80000000, 32'h0);
        checks++;
        if (out_opcode !== 4'b1001 || out_op1 !== 32'h80000000 || out_op2 !== 32'd3 ||
            out_rd !== 5'd5 || out_illegal !== 1'b0) begin
            errors++;
            $display("FAIL imm_srai: got op=%b op1=%h op2=%h rd=%0d ill=%b want 1001 80000000 3 5 0",
                     out_opcode, out_op1, out_op2, out_rd, out_illegal);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_lui_auipc();
        drive(32'h123450B7, 32'h100, 32'hDEAD, 32'hBEEF);
        checks++;
        if (out_opcode !== 4'b0000 || out_op1 !== 32'h0 || out_op2 !== 32'h12345000 || out_rd !== 5'd1) begin
            errors++;
            $display("FAIL lui: got op=%b op1=%h op2=%h rd=%0d want 0000 0 12345000 1",
                     out_opcode, out_op1, out_op2, out_rd);
        end
        drive(32'h12345097, 32'h100, 32'hDEAD, 32'hBEEF);
        checks++;
        if (out_opcode !== 4'b0000 || out_op1 !== 32'h100 || out_op2 !== 32'h12345000) begin
            errors++;
            $display("FAIL auipc: got op=%b op1=%h op2=%h want 0000 100 12345000",
                     out_opcode, out_op1, out_op2);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_illegal();
        drive(32'h00000000, 32'h40, 32'h11, 32'h22);
        checks++;
        if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_opcode !== 4'b0000 ||
            out_op1 !== 32'h0 || out_op2 !== 32'h0) begin
            errors++;
            $display("FAIL ill_zero: got v=%b ill=%b op=%b op1=%h op2=%h want 1 1 0000 0 0",
                     out_valid, out_illegal, out_opcode, out_op1, out_op2);
        end
        drive(32'h40309093, 32'h40, 32'h11, 32'h22);
        checks++;
        if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_opcode !== 4'b0000 ||
            out_op1 !== 32'h0 || out_op2 !== 32'h0 || out_rd !== 5'd1) begin
            errors++;
            $display("FAIL ill_slli: got v=%b ill=%b op=%b op1=%h op2=%h rd=%0d want 1 1 0000 0 0 1",
                     out_valid, out_illegal, out_opcode, out_op1, out_op2, out_rd);
        end
        drive(32'h40209233, 32'h40, 32'h11, 32'h22);
        checks++;
        if (out_illegal !== 1'b1 || out_op1 !== 32'h0) begin
            errors++;
            $display("FAIL ill_op_f7: got ill=%b op1=%h want 1 0", out_illegal, out_op1);
        end
        @(posedge CLK); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ill_consumed: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] pk [4];
        logic [4:0]  got_rd [$];
        logic [31:0] got_op2 [$];
        int nin, nout, cyc;
        logic acc_in, acc_out;
        pk[0] = 32'h00100093; pk[1] = 32'h00200113;
        pk[2] = 32'h00300193; pk[3] = 32'h00400213;
        nin = 0; nout = 0; cyc = 0;
        in_rs1 = 32'h0; out_ready = 1'b0;
        while (nout < 4 && cyc < 40) begin
            if (nin < 4) begin in_valid = 1'b1; in_instr = pk[nin]; end
            else in_valid = 1'b0;
            out_ready = (cyc >= 6);
            acc_in  = in_valid && in_ready;
            acc_out = out_valid && out_ready;
            if (acc_out) begin
                got_rd.push_back(out_rd);
                got_op2.push_back(out_op2);
            end
            @(posedge CLK); #1;
            if (acc_in) begin
                nin++;
                if (nin == 2) begin
                    checks++;
                    if (in_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL bp_ready_after_second: got %b want 0", in_ready);
                    end
                end
            end
            if (acc_out) nout++;
            cyc++;
            if (cyc == 6) begin
                checks++;
                if (nin !== 2) begin
                    errors++;
                    $display("FAIL bp_accept_count: got %0d want 2", nin);
                end
                checks++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_hold_hs: got in_ready=%b out_valid=%b want 0 1", in_ready, out_valid);
                end
                checks++;
                if (out_rd !== 5'd1 || out_op2 !== 32'd1) begin
                    errors++;
                    $display("FAIL bp_stable: got rd=%0d op2=%h want 1 1", out_rd, out_op2);
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (nout != 4) begin
            errors++;
            $display("FAIL bp_delivered: got %0d want 4", nout);
        end
        for (int i = 0; i < got_rd.size(); i++) begin
            checks++;
            if (got_rd[i] !== 5'(i + 1) || got_op2[i] !== 32'(i + 1)) begin
                errors++;
                $display("FAIL bp_order[%0d]: got rd=%0d op2=%h want %0d", i, got_rd[i], got_op2[i], i + 1);
            end
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drained: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_stream();
        out_ready = 1'b0;
        drive(32'h00700393, 32'h0, 32'h0, 32'h0);
        drive(32'h00800413, 32'h0, 32'h0, 32'h0);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_full: got in_ready=%b out_valid=%b want 0 1", in_ready, out_valid);
        end
        #3 RST_N = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || {out_opcode, out_op1, out_op2, out_rd, out_illegal} !== '0) begin
            errors++;
            $display("FAIL rst_mid_clear: got v=%b op2=%h rd=%0d want 0 0 0", out_valid, out_op2, out_rd);
        end
        out_ready = 1'b1;
        #13 RST_N = 1'b1;
        @(posedge CLK); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_ready: got %b want 1", in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_stale[%0d]: got out_valid=%b rd=%0d want 0", i, out_valid, out_rd);
            end
        end
        drive(32'h00900493, 32'h0, 32'h0, 32'h0);
        checks++;
        if (out_valid !== 1'b1 || out_rd !== 5'd9 || out_op2 !== 32'd9) begin
            errors++;
            $display("FAIL rst_mid_resume: got v=%b rd=%0d op2=%h want 1 9 9", out_valid, out_rd, out_op2);
        end
        @(posedge CLK); #1;
    endtask

    initial begin
        test_reset();
        test_op();
        test_imm();
        test_lui_auipc();
        test_illegal();
        test_back_pressure();
        test_reset_mid_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Execute-entry stage that produces the ALU command stream: opcode, op1 and op2.
- Accepts a decoded-slot packet (instruction word, PC, rs1/rs2 read values) over a valid/ready handshake.
- Decodes RV32I OP, OP-IMM, LUI and AUIPC into the 4-bit ALU opcode, selects and extends operands, and registers the result.
- A 2-entry skid buffer lets back-pressure from the execute stage be absorbed without a combinational ready path.

Parameters:
- XLEN, 32, datapath width of op1, op2, pc and rs values.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- in_valid  in  1  input packet valid.
- in_ready  out  1  stage can accept a packet.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction PC.
- in_rs1  in  XLEN  rs1 register value.
- in_rs2  in  XLEN  rs2 register value.
- out_valid  out  1  ALU command valid.
- out_ready  in  1  ALU/execute accepts the command.
- out_opcode  out  4  ALU opcode.
- out_op1  out  XLEN  ALU operand 1.
- out_op2  out  XLEN  ALU operand 2.
- out_rd  out  5  destination register.
- out_illegal  out  1  instruction not in the supported subset.

Behaviour:
- Reset (RST_N low, asynchronous):
  - out_valid=0, in_ready=0, all data outputs 0, both buffer entries empty.
  - in_ready rises on the first CLK edge after RST_N is released.
  - Reset mid-transfer drops all buffered packets; none is replayed.
- ALU opcode encoding (fixed): ADD 0000, SUB 0001, SLT 0010, SLTU 0011, AND 0100, OR 0101, XOR 0110, SLL 0111, SRL 1000, SRA 1001.
- Decode, OP (0110011): opcode selected by funct3/funct7.
  - funct7 0100000 is legal only with funct3 000 (SUB) and 101 (SRA).
  - Every other funct7 other than 0000000 is illegal.
  - op1=rs1, op2=rs2.
- Decode, OP-IMM (0010011): op1=rs1, op2=sign-extended imm[31:20].
  - No SUBI.
  - SLLI requires funct7=0000000.
  - SRLI/SRAI require funct7 0000000 or 0100000.
  - For all three shifts, op2 = zero-extended shamt (instr[24:20]).
- Decode, LUI: opcode ADD, op1=0, op2={instr[31:12],12'b0}.
- Decode, AUIPC: opcode ADD, op1=pc, op2={instr[31:12],12'b0}.
- Illegal packets:
  - Any other major opcode, or an illegal funct combination, sets out_illegal=1 with opcode ADD and op1=op2=0.
  - The packet still flows through the handshake; it is never dropped.
- out_rd = instr[11:7] always.
- Latency: a packet accepted at edge N is on the outputs after edge N, i.e. visible in cycle N+1. Throughput is 1 packet/cycle while out_ready=1.
- Handshake:
  - Transfer occurs when valid&ready are high at the rising edge.
  - out_* are held stable while out_valid=1 and out_ready=0.
  - in_ready is a register output equal to "skid entry empty"; it never depends combinationally on out_ready.
- Buffer states, with allowed transitions:
  - EMPTY → ONE on input accept.
  - ONE → EMPTY on output accept with no input accept.
  - ONE stays ONE on simultaneous input and output accept.
  - ONE → FULL on input accept without output accept.
  - FULL → ONE on output accept; the skid entry moves to the output register.
  - FULL never accepts input (in_ready=0).
- Ordering is strictly FIFO. FULL is reachable only when out_ready falls while in_valid=1.
- in_* are ignored when in_valid=0. Decode happens before the buffer, so the skid entry stores decoded fields.

Decomposition:
- Package alu_pkg:
  - alu_op_t enum (the 10 encodings above).
  - RV32 major opcode constants (OP, OP_IMM, LUI, AUIPC).
  - funct3 constants.
  - alu_cmd_t struct {opcode, op1, op2, rd, illegal}.
- The ALU and its testbench switch to alu_op_t.
- Sub-module alu_decode: purely combinational, instr/pc/rs1/rs2 → alu_cmd_t.
- alu_issue: handshake and skid buffer only.

Test Plan:
- ADD/SUB: instr 0x002081B3 with rs1=5, rs2=7 → opcode 0000, op1=5, op2=7, rd=3, out_valid one cycle after accept. Instr 0x402081B3 → opcode 0001.
- Immediates: ADDI 0xFFF00093 → opcode 0000, op2=0xFFFFFFFF, rd=1. SRAI 0x40335293 with rs1=0x80000000 → opcode 1001, op2=3, rd=5.
- LUI/AUIPC: LUI 0x123450B7 → op1=0, op2=0x12345000. AUIPC 0x12345097 with pc=0x100 → op1=0x100, op2=0x12345000.
- Illegal: instr 0x00000000 and SLLI with funct7=0100000 (0x40309093) → out_illegal=1, opcode 0000, op1=op2=0, still handshaken.
- Back-pressure: stream 4 packets with out_ready held 0 → exactly 2 accepted, in_ready=0 from the edge after the second accept, outputs stable. Releasing out_ready delivers all 4 in order with no duplicates.
- Reset mid-stream: pull RST_N low asynchronously while FULL → out_valid=0 and outputs 0 immediately. After release, in_ready=1 after one edge and no stale packet appears.
